// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: measures divided feedback ticks per window and walks the trim code until lock.
// Optional feature macro PLL_LOCK_MONITOR_EN: keep measuring while locked, re-trim after two bad windows.
`timescale 1ns/1ps
module pll_lock_ctrl #(
    parameter int unsigned TRIM_W     = 4,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned WIN_CYC    = 256,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned TOL        = 2
) (
    input  logic              ref_clk,
    input  logic              porb,
    input  logic              start,
    input  logic              abort,
    input  logic              fb_tick,
    input  logic [CNT_W-1:0]  target_cnt,
    output logic [TRIM_W-1:0] trim_code,
    output logic              enb_vco,
    output logic              enb_cp,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic [CNT_W-1:0]  cnt_last
);

    localparam int unsigned TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned STEP_W  = TRIM_W + 1;
    localparam int unsigned DIFF_W  = CNT_W + 1;

    localparam logic [TRIM_W-1:0] TRIM_MID   = TRIM_W'(1 << (TRIM_W - 1));
    localparam logic [TRIM_W-1:0] TRIM_MAX   = '1;
    localparam logic [STEP_W-1:0] STEP_LIM   = STEP_W'(1 << TRIM_W);
    localparam logic [TMR_W-1:0]  SETTLE_END = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WIN_END    = TMR_W'(WIN_CYC - 1);
    localparam logic [DIFF_W-1:0] TOL_V      = DIFF_W'(TOL);

    typedef enum logic [2:0] {
        S_IDLE, S_ENABLE, S_SETTLE, S_MEASURE, S_EVAL, S_LOCKED, S_FAIL
    } state_t;

    state_t            r_state;
    logic [TRIM_W-1:0] r_trim;
    logic [CNT_W-1:0]  r_target;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_cnt_last;
    logic [TMR_W-1:0]  r_tmr;
    logic [STEP_W-1:0] r_step;
    logic              r_enb_vco;
    logic              r_enb_cp;
    logic              r_busy;
    logic              r_locked;
    logic              r_fail;
`ifdef PLL_LOCK_MONITOR_EN
    logic              r_miss;
`endif

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_win_end;
    logic              w_cnt_lt;
    logic              w_in_tol;
    logic              w_at_rail;
    logic              w_start_ok;

    // Unsigned magnitude of the count error, one bit wider than the counter so it never wraps.
    function automatic logic f_in_tol(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] tgt);
        logic [DIFF_W-1:0] mag;
        mag = (cnt < tgt) ? ({1'b0, tgt} - {1'b0, cnt}) : ({1'b0, cnt} - {1'b0, tgt});
        return (mag <= TOL_V);
    endfunction

    assign w_cnt_nxt  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(fb_tick);
    assign w_win_end  = (r_tmr == WIN_END);
    assign w_cnt_lt   = (r_cnt_last < r_target);
    assign w_in_tol   = f_in_tol(r_cnt_last, r_target);
    assign w_at_rail  = w_cnt_lt ? (r_trim == TRIM_MAX) : (r_trim == '0);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_FAIL));

    assign trim_code = r_trim;
    assign enb_vco   = r_enb_vco;
    assign enb_cp    = r_enb_cp;
    assign busy      = r_busy;
    assign locked    = r_locked;
    assign fail      = r_fail;
    assign cnt_last  = r_cnt_last;

    always_ff @(posedge ref_clk or negedge porb) begin
        if (!porb) begin
            r_state    <= S_IDLE;
            r_trim     <= TRIM_MID;
            r_target   <= '0;
            r_cnt      <= '0;
            r_cnt_last <= '0;
            r_tmr      <= '0;
            r_step     <= '0;
            r_enb_vco  <= 1'b1;
            r_enb_cp   <= 1'b1;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_fail     <= 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
            r_miss     <= 1'b0;
`endif
        end else if (abort) begin
            // Trim is deliberately held so a later restart or debug read sees the last code.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_enb_vco <= 1'b1;
            r_enb_cp  <= 1'b1;
            r_busy    <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
        end else if (w_start_ok) begin
            r_state   <= S_ENABLE;
            r_trim    <= TRIM_MID;
            r_target  <= target_cnt;
            r_step    <= '0;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_enb_vco <= 1'b0;
            r_enb_cp  <= 1'b1;
            r_busy    <= 1'b1;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
            r_miss    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_ENABLE: begin
                    r_state  <= S_SETTLE;
                    r_enb_cp <= 1'b0;
                end
                S_SETTLE: begin
                    if (r_tmr == SETTLE_END) begin
                        r_tmr   <= '0;
                        r_state <= S_MEASURE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (w_win_end) begin
                        r_cnt_last <= w_cnt_nxt;
                        r_cnt      <= '0;
                        r_tmr      <= '0;
                        r_state    <= S_EVAL;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_EVAL: begin
                    if (w_in_tol) begin
                        r_state  <= S_LOCKED;
                        r_busy   <= 1'b0;
                        r_locked <= 1'b1;
                    end else if (w_at_rail || (r_step == STEP_LIM)) begin
                        r_state   <= S_FAIL;
                        r_busy    <= 1'b0;
                        r_fail    <= 1'b1;
                        r_enb_vco <= 1'b1;
                        r_enb_cp  <= 1'b1;
                    end else begin
                        r_trim  <= w_cnt_lt ? r_trim + TRIM_W'(1) : r_trim - TRIM_W'(1);
                        r_step  <= r_step + STEP_W'(1);
                        r_state <= S_SETTLE;
                    end
                end
                S_LOCKED: begin
`ifdef PLL_LOCK_MONITOR_EN
                    // Back-to-back windows; a single bad window is tolerated as noise.
                    if (w_win_end) begin
                        r_cnt_last <= w_cnt_nxt;
                        r_cnt      <= '0;
                        r_tmr      <= '0;
                        if (f_in_tol(w_cnt_nxt, r_target)) begin
                            r_miss <= 1'b0;
                        end else if (r_miss) begin
                            r_miss   <= 1'b0;
                            r_state  <= S_EVAL;
                            r_busy   <= 1'b1;
                            r_locked <= 1'b0;
                        end else begin
                            r_miss <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
`endif
                end
                S_IDLE, S_FAIL: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
